// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C controller receive-side bus monitor.
//   det_state_e   : bus-condition detector state (S_WAIT, S_IDLE, S_BUSY)
//   det_evt_t     : the three one-cycle bus-condition pulses
//   FILT_LEN_DEF  : default glitch-filter length in pclk cycles
//   TBUF_CYC_DEF  : default bus-free (tBUF) idle time in pclk cycles
//   NUM_LINES     : number of monitored bus lines; LINE_SDA / LINE_SCL index them
// ---------------------------------------------------------------------------
package i2c_pkg;

  localparam int FILT_LEN_DEF = 3;
  localparam int TBUF_CYC_DEF = 16;

  localparam int NUM_LINES = 2;
  localparam int LINE_SDA  = 0;
  localparam int LINE_SCL  = 1;

  // S_WAIT: bus high but tBUF not yet elapsed (also the reset state)
  // S_IDLE: bus free for a new START
  // S_BUSY: between a START and its STOP
  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_IDLE = 2'd1,
    S_BUSY = 2'd2
  } det_state_e;

  typedef struct packed {
    logic sta;
    logic rsta;
    logic sto;
  } det_evt_t;

endpackage

// File: rtl/glitch_filter.sv
// ---------------------------------------------------------------------------
// glitch_filter
// Two-flop synchroniser plus optional persistence filter for one bus line.
//   pclk    in  : system clock
//   preset  in  : asynchronous active-high reset (line resets to idle-high)
//   raw     in  : asynchronous pad input
//   filt    out : synchronised (and, when enabled, filtered) line
// Build option: STA_STO_DET_GLITCH_FILTER_EN
//   defined     : the filtered value only follows the synchronised value after
//                 it has differed for FILT_LEN consecutive cycles
//   not defined : filt is the synchroniser output; FILT_LEN is ignored
// ---------------------------------------------------------------------------
module glitch_filter
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int CNT_W    = 8
) (
  input  logic pclk,
  input  logic preset,
  input  logic raw,
  output logic filt
);

  // sync_q[1] is the metastability-safe copy of the pad
  logic [1:0] sync_q;

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], raw};
  end

`ifdef STA_STO_DET_GLITCH_FILTER_EN

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  // cnt_q counts consecutive cycles of disagreement; any agreeing cycle
  // discards the partial run, so short glitches never accumulate.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_q <= sync_q[1];
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign filt = filt_q;

`else

  assign filt = sync_q[1];

  // Parameters stay on the interface so both builds instantiate identically;
  // this empty block only exists for an out-of-range configuration.
  if (FILT_LEN < 1 || CNT_W < 1) begin : g_cfg_range
  end

`endif

endmodule

// File: rtl/sta_sto_det.sv
// ---------------------------------------------------------------------------
// sta_sto_det
// Receive-side I2C bus-condition detector. Synchronises and filters SDA/SCL,
// flags START / repeated START / STOP, and tracks bus busy and bus free (tBUF).
//   pclk      in  : system clock, all logic on rising edge
//   preset    in  : asynchronous active-high reset
//   sda_i     in  : raw SDA pad input (asynchronous)
//   scl_i     in  : raw SCL pad input (asynchronous)
//   sda_filt  out : synchronised/filtered SDA
//   scl_filt  out : synchronised/filtered SCL
//   sta_det   out : 1-cycle pulse on every START (incl. repeated START)
//   rsta_det  out : 1-cycle pulse on a START seen while bus_busy
//   sto_det   out : 1-cycle pulse on STOP
//   bus_busy  out : high from START to the following STOP
//   bus_free  out : high once the bus has been idle-high for TBUF_CYC cycles
// Build option: STA_STO_DET_GLITCH_FILTER_EN enables the per-line glitch
// filter (see glitch_filter); without it FILT_LEN is ignored.
// CNT_W must hold max(FILT_LEN, TBUF_CYC).
// ---------------------------------------------------------------------------
module sta_sto_det
  import i2c_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int TBUF_CYC = TBUF_CYC_DEF,
  parameter int CNT_W    = 8
) (
  input  logic pclk,
  input  logic preset,
  input  logic sda_i,
  input  logic scl_i,
  output logic sda_filt,
  output logic scl_filt,
  output logic sta_det,
  output logic rsta_det,
  output logic sto_det,
  output logic bus_busy,
  output logic bus_free
);

  localparam logic [CNT_W-1:0] TBUF_LAST = CNT_W'(TBUF_CYC - 1);

  // ---------------------------------------------------------------- lines
  logic [NUM_LINES-1:0] line_raw;
  logic [NUM_LINES-1:0] line_f;   // filtered, current cycle
  logic [NUM_LINES-1:0] line_q;   // filtered, one cycle earlier

  assign line_raw[LINE_SDA] = sda_i;
  assign line_raw[LINE_SCL] = scl_i;

  for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
    glitch_filter #(
      .FILT_LEN (FILT_LEN),
      .CNT_W    (CNT_W)
    ) u_filt (
      .pclk   (pclk),
      .preset (preset),
      .raw    (line_raw[i]),
      .filt   (line_f[i])
    );
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) line_q <= '1;
    else        line_q <= line_f;
  end

  assign sda_filt = line_f[LINE_SDA];
  assign scl_filt = line_f[LINE_SCL];

  // ------------------------------------------------------------ detection
  // SCL must be high both before and after the SDA edge, so an SCL edge in
  // the same filtered cycle as the SDA edge is never a bus condition.
  logic scl_stable_hi;
  logic start;
  logic stop;
  logic lines_high;

  assign scl_stable_hi = line_q[LINE_SCL] & line_f[LINE_SCL];
  assign start      = scl_stable_hi &  line_q[LINE_SDA] & ~line_f[LINE_SDA];
  assign stop       = scl_stable_hi & ~line_q[LINE_SDA] &  line_f[LINE_SDA];
  assign lines_high = &line_f;

  // ----------------------------------------------------------------- FSM
  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] tbuf_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT: begin
        if (start)                                 state_d = S_BUSY;
        else if (stop)                             state_d = S_WAIT;
        else if (lines_high && tbuf_q == TBUF_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        // A line pulled low without a START (e.g. SCL stretched by a foreign
        // device) means the bus is no longer known to be free.
        if (start)                   state_d = S_BUSY;
        else if (stop || !lines_high) state_d = S_WAIT;
      end
      S_BUSY: begin
        if (stop) state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state_q <= S_WAIT;
    else        state_q <= state_d;
  end

  // tBUF: counts consecutive idle-high cycles while waiting. A STOP seen in
  // S_WAIT restarts the window; saturation keeps an oversized count from
  // wrapping back into range.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      tbuf_q <= '0;
    end else if (state_q != S_WAIT || state_d != S_WAIT || stop || !lines_high) begin
      tbuf_q <= '0;
    end else if (tbuf_q != '1) begin
      tbuf_q <= tbuf_q + 1'b1;
    end
  end

  // ------------------------------------------------------------- outputs
  // Status is registered from the next state so bus_busy/bus_free move in
  // the same cycle as the corresponding detect pulse.
  det_evt_t evt_d, evt_q;

  always_comb begin
    evt_d      = '0;
    evt_d.sta  = start;
    evt_d.rsta = start && (state_q == S_BUSY);
    evt_d.sto  = stop;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      evt_q    <= '0;
      bus_busy <= 1'b0;
      bus_free <= 1'b0;
    end else begin
      evt_q    <= evt_d;
      bus_busy <= (state_d == S_BUSY);
      bus_free <= (state_d == S_IDLE);
    end
  end

  assign sta_det  = evt_q.sta;
  assign rsta_det = evt_q.rsta;
  assign sto_det  = evt_q.sto;

endmodule

// File: tb/tb_sta_sto_det.sv
// ---------------------------------------------------------------------------
// tb_sta_sto_det
// Directed scenarios followed by random SDA/SCL activity. A reference model
// built from raw-sample history windows predicts every output each cycle.
// Works with or without STA_STO_DET_GLITCH_FILTER_EN.
// ---------------------------------------------------------------------------
module tb_sta_sto_det;

  localparam int FILT_LEN = 3;
  localparam int TBUF_CYC = 16;
  localparam int CNT_W    = 8;
`ifdef STA_STO_DET_GLITCH_FILTER_EN
  localparam int FL = FILT_LEN;
`else
  localparam int FL = 0;
`endif
  // edges from the raw change to the detect pulse
  localparam int PLAT = 3 + FL;
  // glitch length used in the glitch scenarios
  localparam int GL   = 2;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  logic sda_i  = 1'b1;
  logic scl_i  = 1'b1;
  logic sda_filt, scl_filt, sta_det, rsta_det, sto_det, bus_busy, bus_free;

  always #5 pclk = ~pclk;

  sta_sto_det #(
    .FILT_LEN (FILT_LEN),
    .TBUF_CYC (TBUF_CYC),
    .CNT_W    (CNT_W)
  ) dut (
    .pclk     (pclk),
    .preset   (preset),
    .sda_i    (sda_i),
    .scl_i    (scl_i),
    .sda_filt (sda_filt),
    .scl_filt (scl_filt),
    .sta_det  (sta_det),
    .rsta_det (rsta_det),
    .sto_det  (sto_det),
    .bus_busy (bus_busy),
    .bus_free (bus_free)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_sta   = 0;
  int n_sto   = 0;

  // ---------------------------------------------------------------- model
  // m_raw[k]: raw {scl,sda} sampled k edges ago (k=0: this edge)
  logic [1:0] m_raw [0:7];
  logic [1:0] m_f, m_fq;
  logic       m_sta, m_rsta, m_sto, m_busy, m_free;
  int         m_idle;

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_raw[i] = 2'b11;
    m_f = 2'b11; m_fq = 2'b11;
    m_sta = 1'b0; m_rsta = 1'b0; m_sto = 1'b0;
    m_busy = 1'b0; m_free = 1'b0; m_idle = 0;
  endfunction

  function automatic void model_edge(input logic [1:0] smp);
    logic [1:0] cur, prv, nf;
    logic start, stop, high, diff;
    cur = m_f;
    prv = m_fq;
    for (int i = 7; i > 0; i--) m_raw[i] = m_raw[i-1];
    m_raw[0] = smp;
    nf = cur;
    for (int j = 0; j < 2; j++) begin
      if (FL == 0) begin
        nf[j] = m_raw[1][j];
      end else begin
        // line changes once the last FL synchronised samples all disagree
        diff = 1'b1;
        for (int k = 2; k <= FL + 1; k++)
          if (m_raw[k][j] == cur[j]) diff = 1'b0;
        nf[j] = diff ? ~cur[j] : cur[j];
      end
    end
    start = prv[0] & ~cur[0] & prv[1] & cur[1];
    stop  = ~prv[0] & cur[0] & prv[1] & cur[1];
    high  = (cur == 2'b11);
    m_sta  = start;
    m_rsta = start & m_busy;
    m_sto  = stop;
    if (start) begin
      m_busy = 1'b1; m_free = 1'b0; m_idle = 0;
    end else if (stop) begin
      m_busy = 1'b0; m_free = 1'b0; m_idle = 0;
    end else if (m_busy) begin
      m_idle = 0;
    end else if (m_free) begin
      if (!high) m_free = 1'b0;
    end else if (high) begin
      m_idle++;
      if (m_idle == TBUF_CYC) begin
        m_free = 1'b1; m_idle = 0;
      end
    end else begin
      m_idle = 0;
    end
    m_fq = cur;
    m_f  = nf;
  endfunction

  // --------------------------------------------------------------- checks
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    model_edge({scl_i, sda_i});
    #1;
    n_sta += int'(sta_det);
    n_sto += int'(sto_det);
    chk("cycle", {25'd0, sda_filt, scl_filt, sta_det, rsta_det, sto_det, bus_busy, bus_free},
                 {25'd0, m_f[0], m_f[1], m_sta, m_rsta, m_sto, m_busy, m_free});
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset = 1'b1;
    #2;
    model_reset();
    chk("rst_sda_filt", sda_filt, 1);
    chk("rst_scl_filt", scl_filt, 1);
    chk("rst_sta",      sta_det,  0);
    chk("rst_rsta",     rsta_det, 0);
    chk("rst_sto",      sto_det,  0);
    chk("rst_busy",     bus_busy, 0);
    chk("rst_free",     bus_free, 0);
    @(negedge pclk);
    preset = 1'b0;
  endtask

  // ------------------------------------------------------------- stimulus
  initial begin
    int free_at;
    int elapsed;
    int r;

    // reset release, tBUF from reset
    do_reset();
    hold(TBUF_CYC - 1);
    chk("free_pre_tbuf", bus_free, 0);
    tick();
    chk("free_at_tbuf", bus_free, 1);

    // START
    sda_i = 1'b0;
    hold(PLAT - 1);
    chk("sta_early", sta_det, 0);
    tick();
    chk("sta_edge",  sta_det,  1);
    chk("sta_busy",  bus_busy, 1);
    chk("sta_free",  bus_free, 0);
    chk("sta_rsta",  rsta_det, 0);
    tick();
    chk("sta_width", sta_det,  0);

    // repeated START
    scl_i = 1'b0; hold(8);
    sda_i = 1'b1; hold(8);
    scl_i = 1'b1; hold(8);
    sda_i = 1'b0;
    hold(PLAT - 1);
    tick();
    chk("rsta_sta",  sta_det,  1);
    chk("rsta_rsta", rsta_det, 1);
    chk("rsta_busy", bus_busy, 1);
    tick();
    chk("rsta_width", rsta_det, 0);

    // STOP, then a short SDA glitch at cycle 8 of the tBUF window
    sda_i = 1'b1;
    hold(PLAT - 1);
    tick();
    chk("sto_edge", sto_det,  1);
    chk("sto_busy", bus_busy, 0);
    chk("sto_free", bus_free, 0);
    n_sta = 0;
    hold(7);
    sda_i = 1'b0; hold(GL);
    sda_i = 1'b1;
    elapsed = 7 + GL;
    free_at = -1;
    for (int i = 0; i < 60 && free_at < 0; i++) begin
      tick();
      elapsed++;
      if (bus_free) free_at = elapsed;
    end
    chk("tbuf_after_stop", free_at, (FL > GL) ? TBUF_CYC : 7 + GL + PLAT + TBUF_CYC);
    chk("tbuf_glitch_sta", n_sta, (FL > GL) ? 0 : 1);

    // short SDA glitch while idle
    n_sta = 0;
    sda_i = 1'b0; hold(GL);
    sda_i = 1'b1; hold(12);
    chk("idle_glitch_sta",  n_sta,    (FL > GL) ? 0 : 1);
    chk("idle_glitch_free", bus_free, (FL > GL) ? 1 : 0);
    for (int i = 0; i < 40 && !bus_free; i++) tick();
    chk("idle_recover", bus_free, 1);

    // SDA and SCL fall together: not a START
    n_sta = 0; n_sto = 0;
    sda_i = 1'b0; scl_i = 1'b0;
    hold(PLAT + 2);
    chk("simul_sta",  n_sta,    0);
    chk("simul_free", bus_free, 0);
    chk("simul_busy", bus_busy, 0);
    sda_i = 1'b1; scl_i = 1'b1;
    hold(PLAT + 2);
    chk("simul_sto", n_sto, 0);

    // reset mid-transfer, then a STOP without a START
    sda_i = 1'b0;
    hold(PLAT + 1);
    chk("mid_busy", bus_busy, 1);
    scl_i = 1'b0; hold(6);
    do_reset();
    hold(PLAT + 2);
    chk("mid_rst_busy", bus_busy, 0);
    scl_i = 1'b1; hold(8);
    n_sta = 0; n_sto = 0;
    sda_i = 1'b1;
    hold(PLAT + 1);
    chk("mid_sto",  n_sto,    1);
    chk("mid_sta",  n_sta,    0);
    chk("mid_busy_after", bus_busy, 0);

    // random bus activity, including glitches and occasional resets
    for (int it = 0; it < 1500; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35)      sda_i = ~sda_i;
      else if (r < 60) scl_i = ~scl_i;
      else if (r < 70) begin sda_i = ~sda_i; scl_i = ~scl_i; end
      else if (r < 71) do_reset();
      hold(int'($urandom_range(1, 10)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sta_sto_det.md
# sta_sto_det

Bus-condition detector for the APB I2C controller: the receive-side counterpart of the START/STOP generator. It synchronises and filters the raw SDA/SCL pad inputs, then flags START, repeated START and STOP conditions. It also maintains bus-busy and bus-free (tBUF) status, which the master uses for arbitration and start gating and which a future slave/monitor path uses for framing. It sits between the pad input buffers and the byte controller.

## Interface
- FILT_LEN, 3: consecutive stable cycles required before a filtered line changes (≥1)
- TBUF_CYC, 16: idle-high cycles after STOP (or after reset) before bus_free asserts (≥1)
- CNT_W, 8: width of the filter and tBUF counters; must hold max(FILT_LEN, TBUF_CYC)
- pclk  input  1  system clock, all logic on rising edge
- preset  input  1  asynchronous, active-high reset
- sda_i  input  1  raw SDA from pad, asynchronous
- scl_i  input  1  raw SCL from pad, asynchronous
- sda_filt  output  1  synchronised, filtered SDA
- scl_filt  output  1  synchronised, filtered SCL
- sta_det  output  1  one-cycle pulse on every START, including repeated START
- rsta_det  output  1  one-cycle pulse on a START detected while bus_busy=1
- sto_det  output  1  one-cycle pulse on STOP
- bus_busy  output  1  high from a START to the following STOP
- bus_free  output  1  high once the bus has been idle-high for TBUF_CYC cycles

## Operation
- Synchroniser: a 2-FF chain per line, reset to 1.
- Filter, per line:
  - Holds the current filtered value, reset to 1.
  - Counter clears whenever the synced value equals the filtered value and increments while they differ.
  - Filtered value flips when the counter reaches FILT_LEN-1 while still differing; the counter then clears.
- Detection uses the filtered lines and a one-cycle delayed copy (sda_q, scl_q, reset 1):
  - START: sda_q=1, sda_filt=0, scl_q=1, scl_filt=1.
  - STOP: sda_q=0, sda_filt=1, scl_q=1, scl_filt=1.
  - Simultaneous SCL and SDA transitions in the same filtered cycle do not qualify (scl_q=0 or scl_filt=0) and are ignored.
- State machine, registered:
  - S_WAIT (reset state): bus high, tBUF counting.
  - S_IDLE: bus_free=1.
  - S_BUSY: bus_busy=1.
- Transitions:
  - S_WAIT→S_IDLE when the tBUF counter reaches TBUF_CYC-1 with both lines high.
  - S_WAIT/S_IDLE→S_BUSY on START.
  - S_BUSY→S_WAIT on STOP.
  - START in S_BUSY stays in S_BUSY and pulses rsta_det.
- tBUF counter:
  - Counts only in S_WAIT with scl_filt=sda_filt=1.
  - Clears whenever either line is low, or on leaving S_WAIT.
  - Saturates; never wraps.
- STOP in S_WAIT/S_IDLE:
  - sto_det pulses.
  - State goes to S_WAIT, which restarts tBUF.
- A low line in S_IDLE with no START (SCL held low by a foreign device) → S_WAIT.
- Reset mid-transfer: all outputs return to reset values. The bus is treated as not busy until the next START; a STOP seen first pulses sto_det only.

## Timing
- Reset values:
  - sda_filt=1, scl_filt=1
  - sta_det=0, rsta_det=0, sto_det=0
  - bus_busy=0, bus_free=0
- Latency with filter, raw edge sampled at clock edge 0:
  - Synced value changes at edge 2.
  - Filtered value changes at edge 2+FILT_LEN.
  - Pulse is registered and asserts at edge 3+FILT_LEN for exactly one cycle.
- bus_busy and bus_free are registered from the state:
  - bus_busy rises in the same cycle as sta_det.
  - bus_busy falls in the same cycle as sto_det.
  - bus_free falls in the same cycle as sta_det.
- Glitches shorter than FILT_LEN cycles, measured at the synchroniser output, never reach the filtered outputs.

## Configuration
- STA_STO_DET_GLITCH_FILTER_EN defined: filter instantiated as described; FILT_LEN honoured.
- Not defined:
  - sda_filt and scl_filt are the synchroniser outputs directly; FILT_LEN is ignored.
  - Filtered value changes at edge 2; pulse asserts at edge 3.

## Structure
- Shared package i2c_pkg holds:
  - the typedef enum logic [1:0] for the det state (S_WAIT, S_IDLE, S_BUSY)
  - the default FILT_LEN and TBUF_CYC constants
- Sub-module glitch_filter: sync + filter for one line, parameters FILT_LEN and CNT_W, instantiated twice. Its filter stage is guarded by STA_STO_DET_GLITCH_FILTER_EN.

## Test plan
All scenarios use FILT_LEN=3, TBUF_CYC=16, macro defined.
- Reset release with both lines high → all pulses 0, bus_busy=0; bus_free=1 exactly 16 cycles after the filtered lines are high.
- SDA falls with SCL high → sta_det one cycle at edge 6, bus_busy=1, bus_free=0, rsta_det=0.
- Second SDA fall with SCL high while busy → sta_det and rsta_det both pulse once; bus_busy stays 1.
- SDA rises with SCL high while busy → sto_det one cycle, bus_busy=0; bus_free reasserts 16 cycles later. A 2-cycle SDA low glitch at cycle 8 of that window produces no sta_det, but the tBUF count does not restart.
- SDA pulse 2 cycles low with SCL high in S_IDLE → no filtered change, no pulses, bus_free stays 1.
- SDA and SCL fall on the same raw edge → no sta_det; bus_free drops and the state goes to S_WAIT.
